// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage: execute stage of a 32-bit RISC-V pipeline.
//
// Takes the decoded instruction, its operands, its NPC and its fetch tag from
// operand fetch. Produces registered ALU results, resolves branches and jumps,
// and forms load/store addresses and store data. It owns the current-tag
// register: any instruction whose tag no longer matches is squashed to a
// bubble. A taken jump bumps the tag, so the wrong-path instruction in the
// following cycle is killed.
//
// Build option: define MULTI_CYCLE_SHIFT_EN for an iterative 1-bit-per-cycle
// shifter with a SHIFT state that raises busy. Without the macro, shifts use a
// single-cycle barrel shifter and busy is tied low.
//
// Handshake: while busy is 1 the stage ignores its inputs, and upstream holds
// i_in/opA/opB/opC/NPC/tag_in stable. busy falls on the same edge that
// presents the shift result, so upstream may present the next instruction in
// that cycle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_in              decoded instruction (NOP = bubble)
//   opA, opB, opC     rs1/PC, rs2/immediate, store data/branch offset
//   NPC, tag_in       instruction address and its fetch tag
//   busy              stage cannot accept input
//   i_out             retired instruction type (NOP when killed or stalled)
//   result, wr_en     ALU/link/address result and its write-back enable
//   mem_req, mem_we   memory request and per-byte store enables
//   mem_wdata         lane-replicated store data
//   jump, jump_target one-cycle fetch redirect and its address
//   tag_out           current tag
//   dbg_state_o       FSM state (1 = SHIFT), for observation only
// ----------------------------------------------------------------------------
package my_pkg;
  typedef enum logic [5:0] {
    NOP, ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU,
    ADDI, XORI, ORI, ANDI, SLLI, SRLI, SRAI, SLTI, SLTIU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    JAL, JALR, LUI, AUIPC
  } instruction_type;
endpackage

module execute_stage
  import my_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  instruction_type       i_in,
  input  logic [WIDTH-1:0]      opA,
  input  logic [WIDTH-1:0]      opB,
  input  logic [WIDTH-1:0]      opC,
  input  logic [WIDTH-1:0]      NPC,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  busy,
  output instruction_type       i_out,
  output logic [WIDTH-1:0]      result,
  output logic                  wr_en,
  output logic                  mem_req,
  output logic [3:0]            mem_we,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  jump,
  output logic [WIDTH-1:0]      jump_target,
  output logic [TAG_W-1:0]      tag_out,
  output logic                  dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {ACCEPT = 1'b0, SHIFT = 1'b1} state_t;

  instruction_type  i_out_q, i_out_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wr_en_q, wr_en_d;
  logic             mem_req_q, mem_req_d;
  logic [3:0]       mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             jump_q, jump_d;
  logic [WIDTH-1:0] jump_target_q, jump_target_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;

  logic             valid;
  logic [WIDTH-1:0] sum;
  logic [SHW-1:0]   shamt;
  logic             slt_s, slt_u;

`ifdef MULTI_CYCLE_SHIFT_EN
  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_val_q, sh_val_d;
  logic [1:0]       sh_kind_q, sh_kind_d;   // 0 = left, 1 = logical right, 2 = arithmetic right
  instruction_type  sh_ins_q, sh_ins_d;
  logic [WIDTH-1:0] sh_next;
`else
  state_t           state_q;
`endif

  // An instruction carrying a stale tag is squashed to a bubble.
  assign valid = (i_in != NOP) && (tag_in == cur_tag_q);
  assign sum   = opA + opB;
  assign shamt = opB[SHW-1:0];
  assign slt_s = $signed(opA) < $signed(opB);
  assign slt_u = opA < opB;

`ifdef MULTI_CYCLE_SHIFT_EN
  always_comb begin
    sh_next = sh_val_q;
    case (sh_kind_q)
      2'd0:    sh_next = sh_val_q << 1;
      2'd1:    sh_next = sh_val_q >> 1;
      default: sh_next = {sh_val_q[WIDTH-1], sh_val_q[WIDTH-1:1]};
    endcase
  end
`else
  assign state_q = ACCEPT;
`endif

  always_comb begin
    i_out_d       = NOP;
    result_d      = '0;
    wr_en_d       = 1'b0;
    mem_req_d     = 1'b0;
    mem_we_d      = 4'b0000;
    mem_wdata_d   = '0;
    jump_d        = 1'b0;
    jump_target_d = '0;
    cur_tag_d     = cur_tag_q;
`ifdef MULTI_CYCLE_SHIFT_EN
    state_d       = state_q;
    busy_d        = 1'b0;
    cnt_d         = cnt_q;
    sh_val_d      = sh_val_q;
    sh_kind_d     = sh_kind_q;
    sh_ins_d      = sh_ins_q;
`endif

    case (state_q)
      ACCEPT: begin
        if (valid) begin
          i_out_d = i_in;
          case (i_in)
            ADD, ADDI:   begin result_d = sum;         wr_en_d = 1'b1; end
            SUB:         begin result_d = opA - opB;   wr_en_d = 1'b1; end
            XOR, XORI:   begin result_d = opA ^ opB;   wr_en_d = 1'b1; end
            OR, ORI:     begin result_d = opA | opB;   wr_en_d = 1'b1; end
            AND, ANDI:   begin result_d = opA & opB;   wr_en_d = 1'b1; end
            SLT, SLTI:   begin result_d = {{(WIDTH-1){1'b0}}, slt_s}; wr_en_d = 1'b1; end
            SLTU, SLTIU: begin result_d = {{(WIDTH-1){1'b0}}, slt_u}; wr_en_d = 1'b1; end
            SLL, SLLI, SRL, SRLI, SRA, SRAI: begin
`ifdef MULTI_CYCLE_SHIFT_EN
              if (shamt != '0) begin
                // Result is retired later from the SHIFT state.
                i_out_d   = NOP;
                busy_d    = 1'b1;
                state_d   = SHIFT;
                cnt_d     = shamt;
                sh_val_d  = opA;
                sh_ins_d  = i_in;
                sh_kind_d = (i_in == SLL || i_in == SLLI) ? 2'd0 :
                            (i_in == SRL || i_in == SRLI) ? 2'd1 : 2'd2;
              end else begin
                result_d = opA;
                wr_en_d  = 1'b1;
              end
`else
              wr_en_d = 1'b1;
              if (i_in == SLL || i_in == SLLI)      result_d = opA << shamt;
              else if (i_in == SRL || i_in == SRLI) result_d = opA >> shamt;
              else                                  result_d = $signed(opA) >>> shamt;
`endif
            end
            LB, LH, LW, LBU, LHU: begin
              result_d  = sum;
              wr_en_d   = 1'b1;
              mem_req_d = 1'b1;
            end
            SB: begin
              result_d    = sum;
              mem_req_d   = 1'b1;
              mem_we_d    = 4'b0001 << sum[1:0];
              mem_wdata_d = {4{opC[7:0]}};
            end
            SH: begin
              result_d    = sum;
              mem_req_d   = 1'b1;
              mem_we_d    = 4'b0011 << {sum[1], 1'b0};
              mem_wdata_d = {2{opC[15:0]}};
            end
            SW: begin
              result_d    = sum;
              mem_req_d   = 1'b1;
              mem_we_d    = 4'b1111;
              mem_wdata_d = opC;
            end
            BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
              if ((i_in == BEQ  && opA == opB) || (i_in == BNE  && opA != opB) ||
                  (i_in == BLT  && slt_s)      || (i_in == BGE  && !slt_s)     ||
                  (i_in == BLTU && slt_u)      || (i_in == BGEU && !slt_u)) begin
                jump_d        = 1'b1;
                jump_target_d = NPC + opC;
                cur_tag_d     = cur_tag_q + 1'b1;
              end
            end
            JAL, JALR: begin
              result_d      = NPC + WIDTH'(4);
              wr_en_d       = 1'b1;
              jump_d        = 1'b1;
              jump_target_d = (i_in == JALR) ? (sum & ~WIDTH'(1)) : sum;
              cur_tag_d     = cur_tag_q + 1'b1;
            end
            LUI:   begin result_d = opB; wr_en_d = 1'b1; end
            AUIPC: begin result_d = sum; wr_en_d = 1'b1; end
            default: i_out_d = NOP;
          endcase
        end
      end
`ifdef MULTI_CYCLE_SHIFT_EN
      SHIFT: begin
        // Inputs are held by upstream and ignored; no jumps or tag changes here.
        if (cnt_q == SHW'(1)) begin
          result_d = sh_next;
          wr_en_d  = 1'b1;
          i_out_d  = sh_ins_q;
          state_d  = ACCEPT;
        end else begin
          sh_val_d = sh_next;
          cnt_d    = cnt_q - 1'b1;
          busy_d   = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_out_q       <= NOP;
      result_q      <= '0;
      wr_en_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 4'b0000;
      mem_wdata_q   <= '0;
      jump_q        <= 1'b0;
      jump_target_q <= '0;
      cur_tag_q     <= '0;
`ifdef MULTI_CYCLE_SHIFT_EN
      state_q       <= ACCEPT;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      sh_val_q      <= '0;
      sh_kind_q     <= 2'd0;
      sh_ins_q      <= NOP;
`endif
    end else begin
      i_out_q       <= i_out_d;
      result_q      <= result_d;
      wr_en_q       <= wr_en_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      jump_q        <= jump_d;
      jump_target_q <= jump_target_d;
      cur_tag_q     <= cur_tag_d;
`ifdef MULTI_CYCLE_SHIFT_EN
      state_q       <= state_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      sh_val_q      <= sh_val_d;
      sh_kind_q     <= sh_kind_d;
      sh_ins_q      <= sh_ins_d;
`endif
    end
  end

`ifdef MULTI_CYCLE_SHIFT_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign i_out       = i_out_q;
  assign result      = result_q;
  assign wr_en       = wr_en_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign jump        = jump_q;
  assign jump_target = jump_target_q;
  assign tag_out     = cur_tag_q;
  assign dbg_state_o = (state_q == SHIFT);

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage. Inputs change 1ns after each rising edge;
// outputs are sampled 1ns after the edge that registers them.
module tb_execute_stage;
  import my_pkg::*;

  logic            clk;
  logic            reset;
  instruction_type i_in;
  logic [31:0]     opA, opB, opC, NPC;
  logic [3:0]      tag_in;
  logic            busy;
  instruction_type i_out;
  logic [31:0]     result;
  logic            wr_en;
  logic            mem_req;
  logic [3:0]      mem_we;
  logic [31:0]     mem_wdata;
  logic            jump;
  logic [31:0]     jump_target;
  logic [3:0]      tag_out;
  logic            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .i_in(i_in), .opA(opA), .opB(opB), .opC(opC),
    .NPC(NPC), .tag_in(tag_in), .busy(busy), .i_out(i_out), .result(result),
    .wr_en(wr_en), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .jump(jump), .jump_target(jump_target), .tag_out(tag_out),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_in  = NOP;
    opA = '0; opB = '0; opC = '0; NPC = '0; tag_in = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input instruction_type ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] npc, input logic [3:0] t);
    i_in = ins; opA = a; opB = b; opC = c; NPC = npc; tag_in = t;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (i_out !== NOP) begin n_fail++; $display("FAIL reset_i_out: got %0d want NOP", i_out); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (wr_en !== 1'b0 || mem_req !== 1'b0 || jump !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got wr_en=%b mem_req=%b jump=%b want 0", wr_en, mem_req, jump); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (tag_out !== 4'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", tag_out); end
    n_checks++; if (mem_we !== 4'b0 || mem_wdata !== 32'h0 || jump_target !== 32'h0) begin n_fail++; $display("FAIL reset_mem: got we=%b wdata=%h tgt=%h want 0", mem_we, mem_wdata, jump_target); end
  endtask

  task automatic test_alu();
    drive(ADD, 32'd5, 32'd7, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h want %h", result, 32'd12); end
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL add_wr_en: got %b want 1", wr_en); end
    n_checks++; if (i_out !== ADD) begin n_fail++; $display("FAIL add_i_out: got %0d want %0d", i_out, ADD); end
    drive(SUB, 32'd3, 32'd5, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result: got %h want fffffffe", result); end
    drive(SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'd1) begin n_fail++; $display("FAIL slt_signed: got %h want 1", result); end
    drive(SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL sltu_unsigned: got %h want 0", result); end
    drive(LUI, 32'h0, 32'hABCD_E000, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'hABCD_E000 || wr_en !== 1'b1) begin n_fail++; $display("FAIL lui: got %h wr=%b want abcde000 wr=1", result, wr_en); end
    drive(AUIPC, 32'h400, 32'h1000, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'h1400) begin n_fail++; $display("FAIL auipc: got %h want 1400", result); end
    drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
    tick();
    n_checks++; if (i_out !== NOP || wr_en !== 1'b0) begin n_fail++; $display("FAIL nop_bubble: got i_out=%0d wr=%b want NOP 0", i_out, wr_en); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(BEQ, 32'd3, 32'd3, 32'h20, 32'h100, 4'd0);
    tick();
    n_checks++; if (jump !== 1'b1) begin n_fail++; $display("FAIL beq_jump: got %b want 1", jump); end
    n_checks++; if (jump_target !== 32'h120) begin n_fail++; $display("FAIL beq_target: got %h want 120", jump_target); end
    n_checks++; if (tag_out !== 4'd1) begin n_fail++; $display("FAIL beq_tag: got %0d want 1", tag_out); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL beq_wr_en: got %b want 0", wr_en); end
    // Wrong-path instruction still carrying tag 0
    drive(ADD, 32'd1, 32'd1, 32'd0, 32'h104, 4'd0);
    tick();
    n_checks++; if (i_out !== NOP) begin n_fail++; $display("FAIL kill_i_out: got %0d want NOP", i_out); end
    n_checks++; if (wr_en !== 1'b0 || jump !== 1'b0) begin n_fail++; $display("FAIL kill_ctrl: got wr=%b jump=%b want 0 0", wr_en, jump); end
    // Killed store must not reach memory
    drive(SW, 32'h10, 32'h0, 32'h55, 32'h108, 4'd0);
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL kill_store: got mem_req=%b want 0", mem_req); end
    // -5 vs 3: unsigned not less, signed less
    drive(BLTU, 32'hFFFF_FFFB, 32'd3, 32'h40, 32'h200, 4'd1);
    tick();
    n_checks++; if (jump !== 1'b0 || tag_out !== 4'd1) begin n_fail++; $display("FAIL bltu_not_taken: got jump=%b tag=%0d want 0 1", jump, tag_out); end
    drive(BLT, 32'hFFFF_FFFB, 32'd3, 32'h40, 32'h200, 4'd1);
    tick();
    n_checks++; if (jump !== 1'b1 || jump_target !== 32'h240 || tag_out !== 4'd2) begin n_fail++; $display("FAIL blt_taken: got jump=%b tgt=%h tag=%0d want 1 240 2", jump, jump_target, tag_out); end
    drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd2);
    tick();
    n_checks++; if (jump !== 1'b0) begin n_fail++; $display("FAIL jump_pulse: got %b want 0", jump); end
  endtask

  task automatic test_tag_wrap();
    logic [3:0]  exp_tag;
    logic [31:0] a, npc;
    do_reset();
    exp_tag = 4'd0;
    for (int k = 0; k < 16; k++) begin
      a   = 32'h1000 + 32'(k) * 32'h10;
      npc = 32'h2000 + 32'(k) * 32'd4;
      drive(JAL, a, 32'd8, 32'd0, npc, exp_tag);
      tick();
      exp_tag = exp_tag + 4'd1;
      n_checks++; if (jump !== 1'b1 || jump_target !== a + 32'd8) begin n_fail++; $display("FAIL jal%0d_jump: got jump=%b tgt=%h want 1 %h", k, jump, jump_target, a + 32'd8); end
      n_checks++; if (result !== npc + 32'd4 || wr_en !== 1'b1 || tag_out !== exp_tag) begin n_fail++; $display("FAIL jal%0d_link: got res=%h wr=%b tag=%0d want %h 1 %0d", k, result, wr_en, tag_out, npc + 32'd4, exp_tag); end
    end
    n_checks++; if (tag_out !== 4'd0) begin n_fail++; $display("FAIL tag_wrap: got %0d want 0", tag_out); end
    drive(JALR, 32'h3001, 32'h10, 32'd0, 32'h500, 4'd0);
    tick();
    n_checks++; if (jump_target !== 32'h3010 || result !== 32'h504) begin n_fail++; $display("FAIL jalr: got tgt=%h res=%h want 3010 504", jump_target, result); end
    n_checks++; if (tag_out !== 4'd1) begin n_fail++; $display("FAIL jalr_tag: got %0d want 1", tag_out); end
    drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1);
  endtask

  task automatic test_shift();
    do_reset();
    drive(SRA, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 4'd0);
`ifdef MULTI_CYCLE_SHIFT_EN
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (busy !== 1'b1 || i_out !== NOP || wr_en !== 1'b0) begin n_fail++; $display("FAIL sra_busy%0d: got busy=%b i_out=%0d wr=%b want 1 NOP 0", k, busy, i_out, wr_en); end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sra_busy_fall: got %b want 0", busy); end
`else
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sra_busy: got %b want 0", busy); end
`endif
    n_checks++; if (result !== 32'hF800_0000 || wr_en !== 1'b1 || i_out !== SRA) begin n_fail++; $display("FAIL sra_result: got %h wr=%b i_out=%0d want f8000000 1 %0d", result, wr_en, i_out, SRA); end
    drive(SLL, 32'h0000_0003, 32'd0, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'h3 || busy !== 1'b0 || wr_en !== 1'b1) begin n_fail++; $display("FAIL sll_zero: got %h busy=%b wr=%b want 3 0 1", result, busy, wr_en); end
`ifndef MULTI_CYCLE_SHIFT_EN
    drive(SRLI, 32'h8000_0000, 32'd31, 32'd0, 32'h0, 4'd0);
    tick();
    n_checks++; if (result !== 32'h1) begin n_fail++; $display("FAIL srli31: got %h want 1", result); end
`endif
    drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
    tick();
  endtask

  task automatic test_store_load();
    do_reset();
    drive(SB, 32'h1003, 32'h0, 32'hAB, 32'h0, 4'd0);
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 4'b1000) begin n_fail++; $display("FAIL sb_we: got req=%b we=%b want 1 1000", mem_req, mem_we); end
    n_checks++; if (result !== 32'h1003 || mem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_data: got addr=%h wdata=%h want 1003 abababab", result, mem_wdata); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL sb_wr_en: got %b want 0", wr_en); end
    drive(SH, 32'h2000, 32'h2, 32'h5678_1234, 32'h0, 4'd0);
    tick();
    n_checks++; if (mem_we !== 4'b1100 || mem_wdata !== 32'h1234_1234 || result !== 32'h2002) begin n_fail++; $display("FAIL sh: got we=%b wdata=%h addr=%h want 1100 12341234 2002", mem_we, mem_wdata, result); end
    drive(SW, 32'h3C, 32'h4, 32'hDEAD_BEEF, 32'h0, 4'd0);
    tick();
    n_checks++; if (mem_we !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF || result !== 32'h40) begin n_fail++; $display("FAIL sw: got we=%b wdata=%h addr=%h want 1111 deadbeef 40", mem_we, mem_wdata, result); end
    drive(LW, 32'h3C, 32'h4, 32'h0, 32'h0, 4'd0);
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 4'b0000 || wr_en !== 1'b1 || result !== 32'h40) begin n_fail++; $display("FAIL lw: got req=%b we=%b wr=%b addr=%h want 1 0000 1 40", mem_req, mem_we, wr_en, result); end
    drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mem_req_clear: got %b want 0", mem_req); end
  endtask

`ifdef MULTI_CYCLE_SHIFT_EN
  task automatic test_reset_in_shift();
    do_reset();
    // Take one jump first so the tag is non-zero before the abandoned shift.
    drive(JAL, 32'h0, 32'h8, 32'd0, 32'h0, 4'd0);
    tick();
    drive(SRL, 32'hFFFF_FFFF, 32'd20, 32'd0, 32'h0, 4'd1);
    tick();
    tick();
    tick();
    n_checks++; if (busy !== 1'b1 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL shift_in_progress: got busy=%b state=%b want 1 1", busy, dbg_state); end
    reset = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || i_out !== NOP || wr_en !== 1'b0 || tag_out !== 4'd0) begin n_fail++; $display("FAIL reset_in_shift: got busy=%b i_out=%0d wr=%b tag=%0d want 0 NOP 0 0", busy, i_out, wr_en, tag_out); end
    reset = 1'b0;
    drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
    tick();
    n_checks++; if (dbg_state !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL after_reset_in_shift: got state=%b wr=%b want 0 0", dbg_state, wr_en); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
    test_reset();
    test_alu();
    test_branch();
    test_tag_wrap();
    test_shift();
    test_store_load();
`ifdef MULTI_CYCLE_SHIFT_EN
    test_reset_in_shift();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
